level_monitor: RTL and testbench

//  Observation-side counterpart to the constant-level gates (const_high/const_low).

---
 rtl/level_monitor_pkg.sv | 24 ++
 rtl/level_monitor_sat_counter.sv | 38 +++
 rtl/level_monitor.sv | 198 +++++++++++++++++++
 tb/tb_level_monitor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/level_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : level_monitor_pkg
// Brief    : FSM encodings, default sizing and the majority helper shared by
//            the level monitor files.
// Revision : 1.0 - initial release
// ============================================================================
package level_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    localparam int DEFAULT_WINDOW = 32;
    localparam int DEFAULT_CNT_W  = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/level_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : level_monitor_sat_counter
// Brief    : W-bit up counter with synchronous clear that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module level_monitor_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/level_monitor.sv
`default_nettype none
// ============================================================================
// Module   : level_monitor
// Brief    : Samples din for WINDOW cycles after start and reports level
//            pass/fail, stuck flags, toggle count and first mismatch index.
//            Optional LEVEL_MON_FILTER_EN: 3-sample majority filter on din.
// Revision : 1.0 - initial release
// ============================================================================
module level_monitor
    import level_monitor_pkg::*;
#(
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int CNT_W  = DEFAULT_CNT_W,
    localparam int WIN_W = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             din,
    input  logic             expected,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             stuck_high,
    output logic             stuck_low,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [WIN_W-1:0] first_err
);
    localparam logic [WIN_W-1:0] c_last_idx = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] c_no_err   = WIN_W'(WINDOW);

    state_e           state_q, state_d;
    logic [WIN_W-1:0] samp_cnt_q, samp_cnt_d;
    logic             exp_q, exp_d;
    logic             prev_q, prev_d;
    logic             acc_pass_q, acc_pass_d;
    logic             acc_hi_q, acc_hi_d;
    logic             acc_lo_q, acc_lo_d;
    logic [WIN_W-1:0] acc_err_q, acc_err_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             stuck_high_q, stuck_high_d;
    logic             stuck_low_q, stuck_low_d;
    logic [WIN_W-1:0] first_err_q, first_err_d;

    logic w_mon;
    logic w_accept;
    logic w_run;
    logic w_last;
    logic w_mis;
    logic w_tog_inc;

`ifdef LEVEL_MON_FILTER_EN
    // History keeps shifting in every state so the first window sample already
    // has two real predecessors.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = {hist_q[0], din};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign w_mon = majority3(din, hist_q[0], hist_q[1]);
`else
    assign w_mon = din;
`endif

    assign w_accept  = (state_q == ST_IDLE) && start;
    assign w_run     = (state_q == ST_RUN);
    assign w_last    = w_run && (samp_cnt_q == c_last_idx);
    assign w_mis     = (w_mon != exp_q);
    assign w_tog_inc = w_run && (samp_cnt_q != '0) && (w_mon != prev_q);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)  state_d = ST_RUN;
            ST_RUN:    if (w_last) state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = (state_q == ST_RUN);
        done       = done_q;
        pass       = pass_q;
        stuck_high = stuck_high_q;
        stuck_low  = stuck_low_q;
        first_err  = first_err_q;
    end

    // The final sample is folded in combinationally so results land on the
    // same edge that takes the last sample.
    always_comb begin
        samp_cnt_d   = samp_cnt_q;
        exp_d        = exp_q;
        prev_d       = prev_q;
        acc_pass_d   = acc_pass_q;
        acc_hi_d     = acc_hi_q;
        acc_lo_d     = acc_lo_q;
        acc_err_d    = acc_err_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;
        first_err_d  = first_err_q;

        if (w_accept) begin
            exp_d        = expected;
            samp_cnt_d   = '0;
            acc_pass_d   = 1'b1;
            acc_hi_d     = 1'b1;
            acc_lo_d     = 1'b1;
            acc_err_d    = c_no_err;
            pass_d       = 1'b0;
            stuck_high_d = 1'b0;
            stuck_low_d  = 1'b0;
            first_err_d  = '0;
        end else if (w_run) begin
            prev_d     = w_mon;
            samp_cnt_d = samp_cnt_q + 1'b1;
            acc_pass_d = acc_pass_q & ~w_mis;
            acc_hi_d   = acc_hi_q & w_mon;
            acc_lo_d   = acc_lo_q & ~w_mon;
            if ((acc_err_q == c_no_err) && w_mis) begin
                acc_err_d = samp_cnt_q;
            end
            if (w_last) begin
                done_d       = 1'b1;
                pass_d       = acc_pass_d;
                stuck_high_d = acc_hi_d;
                stuck_low_d  = acc_lo_d;
                first_err_d  = acc_err_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_cnt_q   <= '0;
            exp_q        <= 1'b0;
            prev_q       <= 1'b0;
            acc_pass_q   <= 1'b0;
            acc_hi_q     <= 1'b0;
            acc_lo_q     <= 1'b0;
            acc_err_q    <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
            first_err_q  <= '0;
        end else begin
            samp_cnt_q   <= samp_cnt_d;
            exp_q        <= exp_d;
            prev_q       <= prev_d;
            acc_pass_q   <= acc_pass_d;
            acc_hi_q     <= acc_hi_d;
            acc_lo_q     <= acc_lo_d;
            acc_err_q    <= acc_err_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
            first_err_q  <= first_err_d;
        end
    end

    level_monitor_sat_counter #(
        .W (CNT_W)
    ) u_toggle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_accept),
        .inc   (w_tog_inc),
        .q     (toggle_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_level_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_level_monitor
// Brief    : Directed self-checking bench for level_monitor (WINDOW=8 and
//            WINDOW=32 instances sharing stimulus), scoreboard of results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_level_monitor;

    typedef struct packed {
        logic       pass;
        logic       sh;
        logic       sl;
        logic [7:0] tog;
        logic [7:0] ferr;
    } res_t;

    logic clk = 1'b0;
    logic rst_n, start, din, expected;

    logic       busy_a, done_a, pass_a, sh_a, sl_a;
    logic [3:0] tog_a;
    logic [3:0] ferr_a;
    logic       busy_b, done_b, pass_b, sh_b, sl_b;
    logic [3:0] tog_b;
    logic [5:0] ferr_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    level_monitor #(.WINDOW(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .expected(expected),
        .busy(busy_a), .done(done_a), .pass(pass_a), .stuck_high(sh_a),
        .stuck_low(sl_a), .toggle_cnt(tog_a), .first_err(ferr_a)
    );

    level_monitor #(.WINDOW(32), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .expected(expected),
        .busy(busy_b), .done(done_b), .pass(pass_b), .stuck_high(sh_b),
        .stuck_low(sl_b), .toggle_cnt(tog_b), .first_err(ferr_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic res_t observe(input bit use_b);
        res_t r;
        if (use_b) begin
            r.pass = pass_b; r.sh = sh_b; r.sl = sl_b;
            r.tog  = 8'(tog_b); r.ferr = 8'(ferr_b);
        end else begin
            r.pass = pass_a; r.sh = sh_a; r.sl = sl_a;
            r.tog  = 8'(tog_a); r.ferr = 8'(ferr_a);
        end
        return r;
    endfunction

    // Reference model: din held at pat[0] before the start edge.
    function automatic res_t model(input int n, input logic [31:0] pat, input logic e);
        res_t        r;
        logic [31:0] mon;
        for (int i = 0; i < n; i++) begin
`ifdef LEVEL_MON_FILTER_EN
            logic a1, a2;
            a1 = (i >= 1) ? pat[i-1] : pat[0];
            a2 = (i >= 2) ? pat[i-2] : pat[0];
            mon[i] = (pat[i] & a1) | (pat[i] & a2) | (a1 & a2);
`else
            mon[i] = pat[i];
`endif
        end
        r.pass = 1'b1; r.sh = 1'b1; r.sl = 1'b1; r.tog = 8'd0; r.ferr = 8'(n);
        for (int i = 0; i < n; i++) begin
            if (mon[i] != e) begin
                r.pass = 1'b0;
                if (r.ferr == 8'(n)) r.ferr = 8'(i);
            end
            if (!mon[i]) r.sh = 1'b0;
            if (mon[i])  r.sl = 1'b0;
            if (i > 0 && mon[i] != mon[i-1] && r.tog < 8'd15) r.tog = r.tog + 8'd1;
        end
        return r;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy_a && !busy_b && !done_a && !done_b) break;
            tick();
        end
        tick();
        check("wait_idle", {busy_a, busy_b, done_a, done_b}, 0);
    endtask

    task automatic run_window(input string tag, input bit use_b, input int n,
                              input logic [31:0] pat, input logic e, input bit repulse);
        res_t exp_r, got;
        int   early_done;
        wait_idle();
        din = pat[0];
        expected = e;
        tick();
        tick();
        sb.push_back(model(n, pat, e));
        start = 1'b1;
        tick();
        start = 1'b0;
        expected = ~e;
        check({tag, "_busy_run"}, use_b ? busy_b : busy_a, 1);
        early_done = 0;
        for (int i = 0; i < n; i++) begin
            din   = pat[i];
            start = repulse && (i == 2);
            tick();
            start = 1'b0;
            if (i < n - 1 && (use_b ? done_b : done_a)) early_done++;
        end
        check({tag, "_done"}, use_b ? done_b : done_a, 1);
        check({tag, "_busy_end"}, use_b ? busy_b : busy_a, 0);
        check({tag, "_early_done"}, early_done, 0);
        exp_r = sb.pop_front();
        got   = observe(use_b);
        check({tag, "_pass"}, got.pass, exp_r.pass);
        check({tag, "_stuck_high"}, got.sh, exp_r.sh);
        check({tag, "_stuck_low"}, got.sl, exp_r.sl);
        check({tag, "_toggle_cnt"}, got.tog, exp_r.tog);
        check({tag, "_first_err"}, got.ferr, exp_r.ferr);
        if (repulse) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check({tag, "_repulse_busy"}, use_b ? busy_b : busy_a, 0);
            check({tag, "_repulse_done"}, use_b ? done_b : done_a, 0);
            tick();
            check({tag, "_hold_pass"}, observe(use_b), exp_r);
        end
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; din = 1'b0; expected = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {busy_a, done_a, pass_a, sh_a, sl_a, tog_a, ferr_a}, 0);
        rst_n = 1'b1;
        tick();

        run_window("t1_const_high", 1'b0, 8, 32'h0000_00FF, 1'b1, 1'b0);
        run_window("t2_const_low",  1'b0, 8, 32'h0000_0000, 1'b1, 1'b0);
        run_window("t3_alternate",  1'b0, 8, 32'h0000_0055, 1'b1, 1'b0);
        run_window("t4_glitch",     1'b0, 8, 32'h0000_00F7, 1'b1, 1'b0);
`ifndef LEVEL_MON_FILTER_EN
        check("t4_spec_first_err", 32'(ferr_a), 3);
        check("t4_spec_toggle", 32'(tog_a), 2);
`else
        check("t4_spec_pass", 32'(pass_a), 1);
        check("t4_spec_toggle", 32'(tog_a), 0);
`endif

        // Abort mid-run with reset at sample index 4.
        wait_idle();
        din = 1'b1; expected = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = ~din;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_abort_outputs", {busy_a, done_a, pass_a, sh_a, sl_a, tog_a, ferr_a}, 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_a) dones++;
        end
        check("t5_no_done", dones, 0);
        run_window("t5_restart", 1'b0, 8, 32'h0000_00FF, 1'b1, 1'b0);

        run_window("t6_repulse", 1'b0, 8, 32'h0000_00FF, 1'b1, 1'b1);
        run_window("t6_saturate", 1'b1, 32, 32'h5555_5555, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
